// File: rtl/sram_ctrl_pkg.sv
// Shared encodings and default widths for the SRAM initiator controller.
package sram_ctrl_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 8;
   localparam int unsigned DEF_ADDR_WIDTH = 8;
   localparam int unsigned DEF_CNT_WIDTH  = 16;

   typedef enum logic [1:0] {
      OP_READ       = 2'b00,
      OP_WRITE      = 2'b01,
      OP_WR_IF_ZERO = 2'b10,
      OP_ILLEGAL    = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_RD_WAIT,
      ST_WR,
      ST_RESP
   } state_e;

endpackage

// File: rtl/sram_ctrl.sv
// Single-request SRAM initiator: read / write / write-if-zero with registered-read
// capture, response handshake, saturating write counter and deferred dump strobe.
module sram_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [1:0]            req_op,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_data,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_data,
   output logic                  resp_written,
   output logic                  resp_err,
   input  logic                  dump_req,
   output logic                  sram_cs,
   output logic                  sram_we,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic [DATA_WIDTH-1:0] sram_wdata,
   input  logic [DATA_WIDTH-1:0] sram_rdata,
   output logic                  sram_dump,
   output logic [CNT_WIDTH-1:0]  wr_count
);

   state_e                state, state_n;
   op_e                   op_q, op_n;
   logic [DATA_WIDTH-1:0] data_q, data_n;
   logic                  dump_pend, pend_n;
   logic                  cs_n, we_n, rv_n, rw_n, re_n, dump_n, cnt_inc;
   logic [ADDR_WIDTH-1:0] addr_n;
   logic [DATA_WIDTH-1:0] wdata_n, rd_n;
   logic [CNT_WIDTH-1:0]  cnt_n;

   // dump_req gates acceptance in the same cycle it arrives
   assign req_ready = (state == ST_IDLE) && !resp_valid && !sram_dump
                      && !dump_pend && !dump_req;

   always_comb begin
      state_n = state;
      op_n    = op_q;
      data_n  = data_q;
      pend_n  = dump_pend | dump_req;
      dump_n  = sram_dump;
      cs_n    = 1'b0;
      we_n    = 1'b0;
      addr_n  = sram_addr;
      wdata_n = sram_wdata;
      rv_n    = resp_valid;
      rd_n    = resp_data;
      rw_n    = resp_written;
      re_n    = resp_err;
      cnt_inc = 1'b0;

      case (state)
         ST_IDLE: begin
            if (dump_pend && !resp_valid)
               dump_n = 1'b1;
            if (req_valid && req_ready) begin
               op_n   = op_e'(req_op);
               data_n = req_data;
               addr_n = req_addr;
               rd_n   = '0;
               rw_n   = 1'b0;
               re_n   = 1'b0;
               case (op_e'(req_op))
                  OP_READ, OP_WR_IF_ZERO: begin
                     state_n = ST_RD;
                     cs_n    = 1'b1;
                  end
                  OP_WRITE: begin
                     state_n = ST_WR;
                     cs_n    = 1'b1;
                     we_n    = 1'b1;
                     wdata_n = req_data;
                  end
                  default: state_n = ST_RESP;
               endcase
            end
         end
         ST_RD: state_n = ST_RD_WAIT;
         ST_RD_WAIT: begin
            rd_n = sram_rdata;
            if (op_q == OP_WR_IF_ZERO && sram_rdata == '0) begin
               state_n = ST_WR;
               cs_n    = 1'b1;
               we_n    = 1'b1;
               wdata_n = data_q;
            end else begin
               rv_n    = 1'b1;
               state_n = ST_RESP;
            end
         end
         ST_WR: begin
            rv_n    = 1'b1;
            rw_n    = 1'b1;
            cnt_inc = 1'b1;
            state_n = ST_RESP;
         end
         ST_RESP: begin
            // Entering RESP without a response only happens for an illegal op
            if (!resp_valid) begin
               rv_n = 1'b1;
               re_n = (op_q == OP_ILLEGAL);
            end else if (resp_ready) begin
               rv_n    = 1'b0;
               state_n = ST_IDLE;
            end
         end
         default: state_n = ST_IDLE;
      endcase

      cnt_n = wr_count;
      if (cnt_inc && wr_count != '1)
         cnt_n = wr_count + CNT_WIDTH'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         op_q         <= OP_READ;
         data_q       <= '0;
         dump_pend    <= 1'b0;
         sram_dump    <= 1'b0;
         sram_cs      <= 1'b0;
         sram_we      <= 1'b0;
         sram_addr    <= '0;
         sram_wdata   <= '0;
         resp_valid   <= 1'b0;
         resp_data    <= '0;
         resp_written <= 1'b0;
         resp_err     <= 1'b0;
         wr_count     <= '0;
      end else begin
         state        <= state_n;
         op_q         <= op_n;
         data_q       <= data_n;
         dump_pend    <= pend_n;
         sram_dump    <= dump_n;
         sram_cs      <= cs_n;
         sram_we      <= we_n;
         sram_addr    <= addr_n;
         sram_wdata   <= wdata_n;
         resp_valid   <= rv_n;
         resp_data    <= rd_n;
         resp_written <= rw_n;
         resp_err     <= re_n;
         wr_count     <= cnt_n;
      end
   end

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: behavioural SRAM plus an array/latency reference model,
// directed cases from the plan followed by randomized traffic.
module tb_sram_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready;
   logic [1:0]  req_op;
   logic [7:0]  req_addr, req_data;
   logic        resp_valid, resp_ready;
   logic [7:0]  resp_data;
   logic        resp_written, resp_err;
   logic        dump_req;
   logic        sram_cs, sram_we;
   logic [7:0]  sram_addr, sram_wdata, sram_rdata;
   logic        sram_dump;
   logic [15:0] wr_count;

   logic [7:0]  mem     [256];
   logic [7:0]  ref_mem [256];
   int unsigned ref_cnt;
   int unsigned total = 0;
   int unsigned bad   = 0;

   sram_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_data(req_data),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .resp_written(resp_written), .resp_err(resp_err),
      .dump_req(dump_req),
      .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
      .sram_dump(sram_dump), .wr_count(wr_count)
   );

   always #5 clk = ~clk;

   // SRAM with registered read
   always @(posedge clk) begin
      if (sram_cs) begin
         if (sram_we) mem[sram_addr] <= sram_wdata;
         else         sram_rdata     <= mem[sram_addr];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Issue one op, check latency, SRAM activity and response, then accept after `hold` stall cycles.
   task automatic do_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d,
                        input int unsigned hold, input int dump_at);
      int unsigned k, w, ncs, nwe, nbad, e_lat, e_cs, e_we;
      logic [7:0]  e_data;
      logic        e_wr, e_err;
      e_data = 8'h00; e_wr = 1'b0; e_err = 1'b0;
      case (op)
         2'b00: begin e_data = ref_mem[a]; e_lat = 2; e_cs = 1; e_we = 0; end
         2'b01: begin ref_mem[a] = d; e_wr = 1'b1; e_lat = 1; e_cs = 1; e_we = 1; end
         2'b10: begin
            e_data = ref_mem[a];
            if (e_data == 8'h00) begin
               ref_mem[a] = d; e_wr = 1'b1; e_lat = 3; e_cs = 2; e_we = 1;
            end else begin
               e_lat = 2; e_cs = 1; e_we = 0;
            end
         end
         default: begin e_err = 1'b1; e_lat = 1; e_cs = 0; e_we = 0; end
      endcase
      if (e_wr && ref_cnt != 32'hFFFF) ref_cnt++;

      w = 0;
      while (!req_ready && w < 50) begin @(negedge clk); w++; end
      check("req_ready_idle", req_ready, 1);
      req_valid = 1'b1; req_op = op; req_addr = a; req_data = d;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0; req_op = 2'($urandom); req_addr = 8'($urandom); req_data = 8'($urandom);

      k = 0; ncs = 0; nwe = 0; nbad = 0;
      while (!resp_valid && k < 20) begin
         dump_req = (int'(k) == dump_at);
         if (sram_cs) ncs++;
         if (sram_cs && sram_we) nwe++;
         if (sram_we && !sram_cs) nbad++;
         if (sram_cs && sram_addr != a) nbad++;
         if (sram_cs && sram_we && sram_wdata != d) nbad++;
         @(negedge clk);
         k++;
      end
      dump_req = 1'b0;
      check("latency", k, e_lat);
      check("cs_cycles", ncs, e_cs);
      check("we_cycles", nwe, e_we);
      check("bus_errors", nbad, 0);
      check("resp_data", resp_data, e_data);
      check("resp_written", resp_written, e_wr);
      check("resp_err", resp_err, e_err);
      check("wr_count", wr_count, ref_cnt);
      check("req_ready_busy", req_ready, 0);

      for (int unsigned i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_valid", resp_valid, 1);
         check("hold_data", resp_data, e_data);
         check("hold_written", resp_written, e_wr);
         check("hold_ready", req_ready, 0);
         check("hold_cs", sram_cs, 0);
         check("hold_dump", sram_dump, 0);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      check("resp_cleared", resp_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int unsigned mm;
      logic [7:0]  v;
      rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_addr = '0; req_data = '0;
      resp_ready = 1'b0; dump_req = 1'b0; ref_cnt = 0;
      for (int unsigned i = 0; i < 256; i++) begin
         v = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         mem[i] = v; ref_mem[i] = v;
      end
      mem[5] = 8'h3C; ref_mem[5] = 8'h3C;
      mem[0] = 8'h00; ref_mem[0] = 8'h00;

      repeat (3) @(negedge clk);
      check("rst_valid", resp_valid, 0);
      check("rst_cs", sram_cs, 0);
      check("rst_count", wr_count, 0);
      check("rst_dump", sram_dump, 0);
      rst = 1'b0;
      @(negedge clk);

      do_op(2'b00, 8'd5, 8'h00, 0, -1);
      do_op(2'b01, 8'd9, 8'hA5, 1, -1);
      do_op(2'b00, 8'd9, 8'h00, 0, -1);
      do_op(2'b10, 8'd0, 8'h07, 0, -1);
      do_op(2'b10, 8'd0, 8'h09, 2, -1);
      do_op(2'b00, 8'd0, 8'h00, 0, -1);
      do_op(2'b11, 8'd3, 8'h55, 1, -1);
      do_op(2'b00, 8'd5, 8'h00, 5, -1);

      // reset while the read sits in RD_WAIT
      req_valid = 1'b1; req_op = 2'b00; req_addr = 8'd9;
      @(posedge clk); @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_valid", resp_valid, 0);
      check("mid_rst_cs", sram_cs, 0);
      check("mid_rst_we", sram_we, 0);
      check("mid_rst_addr", sram_addr, 0);
      check("mid_rst_data", resp_data, 0);
      check("mid_rst_count", wr_count, 0);
      check("mid_rst_ready", req_ready, 1);
      rst = 1'b0;
      ref_cnt = 0;
      repeat (3) begin
         @(negedge clk);
         check("mid_rst_no_resp", resp_valid, 0);
      end
      do_op(2'b00, 8'd9, 8'h00, 0, -1);

      for (int n = 0; n < 60; n++) begin
         v = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         do_op(2'($urandom), 8'($urandom_range(0, 15)), v, $urandom_range(0, 3), -1);
      end

      // dump requested while a write-if-zero is outstanding
      mem[40] = 8'h00; ref_mem[40] = 8'h00;
      do_op(2'b10, 8'd40, 8'h66, 3, 1);
      check("dump_not_yet", sram_dump, 0);
      check("dump_pend_ready", req_ready, 0);
      @(negedge clk);
      check("dump_set", sram_dump, 1);
      check("dump_ready", req_ready, 0);
      req_valid = 1'b1; req_op = 2'b00; req_addr = 8'd5;
      mm = 0;
      repeat (5) begin
         @(negedge clk);
         if (req_ready || sram_cs || resp_valid || !sram_dump) mm++;
      end
      req_valid = 1'b0;
      check("dump_blocks_req", mm, 0);

      mm = 0;
      for (int unsigned i = 0; i < 256; i++)
         if (mem[i] !== ref_mem[i]) mm++;
      check("mem_contents", mm, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
